// File: rtl/cia_sercom_uart.sv
// cia_sercom_uart: C64 user-port RS232 <-> IO-controller byte link.
// Optional RTS/CTS flow control: define SERCOM_FLOWCTL_EN.
module cia_sercom_uart #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             phi2_p,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             txd,
  output logic             rxd,
  input  logic             rts,
  output logic             cts,
  output logic             out_available,
  input  logic             out_strobe,
  output logic [7:0]       out_data,
  input  logic             in_strobe,
  input  logic [7:0]       in_data,
  input  logic             status_clr,
  output logic [15:0]      status
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HI = FIFO_DEPTH - 2;
  localparam logic [AW:0] LVL_FULL = FIFO_DEPTH[AW:0];
  localparam logic [AW:0] LVL_HI   = HI[AW:0];

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_STOP, T_BREAK
  } tstate_t;

  typedef enum logic [1:0] {
    R_IDLE, R_START, R_DATA, R_STOP
  } rstate_t;

  tstate_t          t_state, t_next;
  logic [DIV_W-1:0] t_cnt, t_div, t_load_val;
  logic [2:0]       t_bit;
  logic [7:0]       t_sr;
  logic             t_ev, t_load, t_latch;
  logic             t_shift, t_push, t_ferr;

  rstate_t          r_state, r_next;
  logic [DIV_W-1:0] r_cnt, r_div, r_load_val;
  logic [2:0]       r_bit;
  logic [7:0]       r_sr;
  logic             r_ev, r_load, r_take;
  logic             r_shift, r_rxd_n, r_go, rts_ok;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, do_push, do_pop;

  logic             hold_full;
  logic [7:0]       hold_data;
  logic             ovf, ferr, drop;
  logic             t_busy, r_busy;
  logic [4:0]       lvl;

  assign t_ev = phi2_p && (t_cnt == '0);
  assign r_ev = phi2_p && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) t_state <= T_IDLE;
    else       t_state <= t_next;
  end

  always_comb begin
    t_next     = t_state;
    t_load     = 1'b0;
    t_load_val = t_div;
    t_latch    = 1'b0;
    t_shift    = 1'b0;
    t_push     = 1'b0;
    t_ferr     = 1'b0;
    unique case (t_state)
      T_IDLE: if (phi2_p && !txd) begin
        t_next     = T_START;
        t_load     = 1'b1;
        t_load_val = baud_div >> 1;
        t_latch    = 1'b1;
      end
      T_START: if (t_ev) begin
        if (!txd) begin
          t_next = T_DATA;
          t_load = 1'b1;
        end else begin
          t_next = T_IDLE;
        end
      end
      T_DATA: if (t_ev) begin
        t_shift = 1'b1;
        t_load  = 1'b1;
        if (t_bit == 3'd7) t_next = T_STOP;
      end
      T_STOP: if (t_ev) begin
        if (txd) begin
          t_push = 1'b1;
          t_next = T_IDLE;
        end else begin
          t_ferr = 1'b1;
          t_next = T_BREAK;
        end
      end
      T_BREAK: if (phi2_p && txd) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  // Start uses a half-bit load so every later sample lands mid-bit
  always_ff @(posedge clk) begin
    if (reset) begin
      t_cnt <= '0;
      t_div <= '0;
      t_bit <= '0;
      t_sr  <= '0;
    end else begin
      if (t_load) t_cnt <= t_load_val;
      else if (phi2_p && t_cnt != '0) t_cnt <= t_cnt - 1'b1;
      if (t_latch) t_div <= baud_div;
      if (t_state == T_START) t_bit <= '0;
      else if (t_shift) t_bit <= t_bit + 1'b1;
      if (t_shift) t_sr <= {txd, t_sr[7:1]};
    end
  end

  assign full    = (count == LVL_FULL);
  assign empty   = (count == '0);
  assign do_push = t_push && !full;
  assign do_pop  = out_strobe && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= t_sr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: count <= count + 1'b1;
        do_pop && !do_push: count <= count - 1'b1;
        default:            count <= count;
      endcase
    end
  end

  assign out_available = !empty;
  assign out_data      = empty ? 8'h00 : mem[rd_ptr];

`ifdef SERCOM_FLOWCTL_EN
  assign rts_ok = rts;

  always_ff @(posedge clk) begin
    if (reset) cts <= 1'b1;
    else       cts <= (count < LVL_HI);
  end
`else
  logic unused_rts;
  assign unused_rts = rts;
  assign rts_ok     = 1'b1;

  always_ff @(posedge clk) begin
    if (reset) cts <= 1'b1;
    else       cts <= 1'b1;
  end
`endif

  assign r_go = hold_full && rts_ok;

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next     = r_state;
    r_load     = 1'b0;
    r_take     = 1'b0;
    r_shift    = 1'b0;
    r_rxd_n    = rxd;
    r_load_val = r_div;
    unique case (r_state)
      R_IDLE: if (r_go) begin
        r_next  = R_START;
        r_take  = 1'b1;
        r_load  = 1'b1;
        r_rxd_n = 1'b0;
      end
      R_START: if (r_ev) begin
        r_next  = R_DATA;
        r_load  = 1'b1;
        r_shift = 1'b1;
        r_rxd_n = r_sr[0];
      end
      R_DATA: if (r_ev) begin
        r_load = 1'b1;
        if (r_bit == 3'd7) begin
          r_next  = R_STOP;
          r_rxd_n = 1'b1;
        end else begin
          r_shift = 1'b1;
          r_rxd_n = r_sr[0];
        end
      end
      R_STOP: if (r_ev) begin
        // Chain straight into the next start bit when a byte waits
        if (r_go) begin
          r_next  = R_START;
          r_take  = 1'b1;
          r_load  = 1'b1;
          r_rxd_n = 1'b0;
        end else begin
          r_next = R_IDLE;
        end
      end
      default: r_next = R_IDLE;
    endcase
    if (r_take) r_load_val = baud_div;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_div     <= '0;
      r_bit     <= '0;
      r_sr      <= '0;
      rxd       <= 1'b1;
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      rxd <= r_rxd_n;
      if (r_load) r_cnt <= r_load_val;
      else if (phi2_p && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (r_take) r_div <= baud_div;
      if (r_take) r_sr <= hold_data;
      else if (r_shift) r_sr <= {1'b0, r_sr[7:1]};
      if (r_state == R_START) r_bit <= '0;
      else if (r_shift) r_bit <= r_bit + 1'b1;
      if (r_take) hold_full <= 1'b0;
      if (in_strobe && !hold_full) begin
        hold_full <= 1'b1;
        hold_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf  <= 1'b0;
      ferr <= 1'b0;
      drop <= 1'b0;
    end else begin
      ovf  <= (t_push && full) || (ovf && !status_clr);
      ferr <= t_ferr || (ferr && !status_clr);
      drop <= (in_strobe && hold_full) || (drop && !status_clr);
    end
  end

  assign t_busy = (t_state == T_START) || (t_state == T_DATA) ||
                  (t_state == T_STOP);
  assign r_busy = (r_state != R_IDLE);
  assign lvl    = 5'(count);
  assign status = {5'b0, t_busy, r_busy, hold_full,
                   drop, ferr, ovf, lvl};

endmodule

// File: tb/tb_cia_sercom_uart.sv
// Bench for cia_sercom_uart: directed vector table, hand-written timing
// sequences and a randomized TX run against a queue FIFO model.
`timescale 1ns/1ps
module tb_cia_sercom_uart;

  logic        clk = 0;
  logic        reset = 1;
  logic        phi2_p = 0;
  logic [15:0] baud_div = 16'd3;
  logic        txd = 1;
  logic        rxd;
  logic        rts = 1;
  logic        cts;
  logic        out_available;
  logic        out_strobe = 0;
  logic [7:0]  out_data;
  logic        in_strobe = 0;
  logic [7:0]  in_data = 0;
  logic        status_clr = 0;
  logic [15:0] status;

  int checks = 0;
  int errors = 0;
  int pc = 0;

  cia_sercom_uart dut (
    .clk(clk), .reset(reset), .phi2_p(phi2_p),
    .baud_div(baud_div), .txd(txd), .rxd(rxd),
    .rts(rts), .cts(cts), .out_available(out_available),
    .out_strobe(out_strobe), .out_data(out_data),
    .in_strobe(in_strobe), .in_data(in_data),
    .status_clr(status_clr), .status(status)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    pc = (pc + 1) % 8;
    phi2_p = (pc == 0);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  task automatic phi_tick();
    @(posedge clk);
    while (!phi2_p) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] b;
    b = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      txd = b[i];
      repeat (4) phi_tick();
    end
    txd = 1'b1;
    repeat (4) phi_tick();
  endtask

  task automatic glitch();
    txd = 1'b0;
    phi_tick();
    txd = 1'b1;
    repeat (6) phi_tick();
  endtask

  task automatic pop();
    out_strobe = 1'b1;
    @(negedge clk);
    out_strobe = 1'b0;
  endtask

  task automatic clr();
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] d);
    in_data = d;
    in_strobe = 1'b1;
    @(negedge clk);
    in_strobe = 1'b0;
  endtask

  task automatic check_slots(input logic [7:0] b0, input logic [7:0] b1,
                             input int n, input string nm);
    logic [19:0] e;
    e = {1'b1, b1, 1'b0, 1'b1, b0, 1'b0};
    for (int s = 0; s < n * 10; s++) begin
      chk($sformatf("%s_rxd%0d", nm, s), 16'(rxd), 16'(e[s]));
      chk($sformatf("%s_busy%0d", nm, s), 16'(status[9]), 16'h1);
      repeat (4) phi_tick();
    end
    chk({nm, "_idle_rxd"}, 16'(rxd), 16'h1);
    chk({nm, "_idle_busy"}, 16'(status[9]), 16'h0);
  endtask

  task automatic rx_test(input logic [7:0] b0, input logic [7:0] b1,
                         input bit two, input string nm);
    strobe(b0);
    @(negedge clk);
    if (two) begin
      in_data = b1;
      in_strobe = 1'b1;
      fork
        begin
          @(negedge clk);
          in_strobe = 1'b0;
        end
      join_none
    end
    check_slots(b0, b1, two ? 2 : 1, nm);
  endtask

  typedef struct {
    bit         gl;
    logic [7:0] d;
    logic       stop;
    logic       exp_av;
    logic [7:0] exp_d;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] q[$];
  logic [7:0] rd;
  logic [7:0] ra, rb;
  logic       movf;
  logic [9:0] fb;

  initial begin
    tbl[0] = '{1'b0, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0};
    tbl[3] = '{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{1'b0, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_rxd", 16'(rxd), 16'h1);
    chk("rst_cts", 16'(cts), 16'h1);
    chk("rst_avail", 16'(out_available), 16'h0);
    chk("rst_data", 16'(out_data), 16'h0);
    chk("rst_status", status, 16'h0000);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      if (tbl[i].gl) glitch();
      else send_frame(tbl[i].d, tbl[i].stop);
      chk($sformatf("v%0d_avail", i), 16'(out_available),
          16'(tbl[i].exp_av));
      chk($sformatf("v%0d_data", i), 16'(out_data), 16'(tbl[i].exp_d));
      chk($sformatf("v%0d_ferr", i), 16'(status[6]),
          16'(tbl[i].exp_ferr));
      chk($sformatf("v%0d_lvl", i), 16'(status[4:0]),
          16'(tbl[i].exp_av));
      if (tbl[i].exp_av) pop();
      chk($sformatf("v%0d_popped", i), 16'(out_available), 16'h0);
      clr();
      chk($sformatf("v%0d_clr", i), 16'(status[7:5]), 16'h0);
    end

    fb = {1'b1, 8'h5A, 1'b0};
    for (int i = 0; i < 9; i++) begin
      txd = fb[i];
      repeat (4) phi_tick();
    end
    txd = 1'b1;
    repeat (2) phi_tick();
    chk("stop_pre_avail", 16'(out_available), 16'h0);
    chk("stop_busy", 16'(status[10]), 16'h1);
    phi_tick();
    chk("stop_post_avail", 16'(out_available), 16'h1);
    chk("stop_post_data", 16'(out_data), 16'h5A);
    repeat (5) phi_tick();
    pop();
    chk("stop_pop_avail", 16'(out_available), 16'h0);
    chk("stop_pop_lvl", 16'(status[4:0]), 16'h0);

    for (int i = 1; i <= 17; i++) send_frame(8'(i), 1'b1);
    chk("ovf_lvl", 16'(status[4:0]), 16'd16);
    chk("ovf_flag", 16'(status[5]), 16'h1);
    for (int i = 1; i <= 16; i++) begin
      chk($sformatf("ovf_pop%0d", i), 16'(out_data), 16'(i));
      pop();
    end
    chk("ovf_empty", 16'(out_available), 16'h0);
    clr();
    chk("ovf_clr", 16'(status[5]), 16'h0);

    q.delete();
    movf = 1'b0;
    for (int k = 0; k < 36; k++) begin
      if ($urandom_range(0, 9) < 8) begin
        rd = 8'($urandom);
        send_frame(rd, 1'b1);
        if (q.size() < 16) q.push_back(rd);
        else movf = 1'b1;
      end else begin
        pop();
        if (q.size() > 0) void'(q.pop_front());
      end
      chk($sformatf("rnd%0d_avail", k), 16'(out_available),
          16'(q.size() != 0));
      chk($sformatf("rnd%0d_data", k), 16'(out_data),
          16'(q.size() != 0 ? q[0] : 8'h00));
      chk($sformatf("rnd%0d_lvl", k), 16'(status[4:0]), 16'(q.size()));
      chk($sformatf("rnd%0d_ovf", k), 16'(status[5]), 16'(movf));
    end
    while (q.size() > 0) begin
      chk("rnd_drain", 16'(out_data), 16'(q[0]));
      void'(q.pop_front());
      pop();
    end
    chk("rnd_drained", 16'(out_available), 16'h0);
    clr();

    rx_test(8'hC3, 8'h00, 1'b0, "rx_c3");
    for (int k = 0; k < 3; k++) begin
      ra = 8'($urandom);
      rx_test(ra, 8'h00, 1'b0, $sformatf("rx_rnd%0d", k));
    end
    ra = 8'($urandom);
    rb = 8'($urandom);
    rx_test(ra, rb, 1'b1, "rx_b2b");

`ifdef SERCOM_FLOWCTL_EN
    rts = 1'b0;
    strobe(8'h11);
    repeat (8) phi_tick();
    chk("fc_hold_rxd", 16'(rxd), 16'h1);
    chk("fc_hold_full", 16'(status[8]), 16'h1);
    chk("fc_hold_idle", 16'(status[9]), 16'h0);
    strobe(8'h22);
    chk("fc_drop", 16'(status[7]), 16'h1);
    rts = 1'b1;
    @(negedge clk);
    check_slots(8'h11, 8'h00, 1, "fc_go");
    clr();
    chk("fc_drop_clr", 16'(status[7]), 16'h0);
    for (int i = 0; i < 13; i++) send_frame(8'(i), 1'b1);
    chk("fc_cts13", 16'(cts), 16'h1);
    send_frame(8'hEE, 1'b1);
    chk("fc_cts14", 16'(cts), 16'h0);
    for (int i = 0; i < 14; i++) pop();
    repeat (2) @(negedge clk);
    chk("fc_cts_empty", 16'(cts), 16'h1);
`else
    rts = 1'b0;
    rx_test(8'h11, 8'h00, 1'b0, "nofc_rts0");
    strobe(8'h33);
    strobe(8'h44);
    chk("nofc_drop", 16'(status[7]), 16'h1);
    repeat (45) phi_tick();
    clr();
    chk("nofc_drop_clr", 16'(status[7]), 16'h0);
    for (int i = 0; i < 14; i++) send_frame(8'(i), 1'b1);
    chk("nofc_cts14", 16'(cts), 16'h1);
    chk("nofc_lvl14", 16'(status[4:0]), 16'd14);
    for (int i = 0; i < 14; i++) pop();
    rts = 1'b1;
`endif

    send_frame(8'h77, 1'b1);
    strobe(8'h0F);
    @(negedge clk);
    repeat (2) phi_tick();
    chk("mid_rxd_low", 16'(rxd), 16'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rxd", 16'(rxd), 16'h1);
    chk("mid_rst_status", status, 16'h0000);
    chk("mid_rst_avail", 16'(out_available), 16'h0);
    reset = 1'b0;
    repeat (20) phi_tick();
    chk("post_rst_rxd", 16'(rxd), 16'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
